// File: rtl/link_monitor.sv
// Runtime link/clock health watchdog: qualifies lock and GBT status, counts drops and glitches.
// Optional macro LINK_MONITOR_AUTORESET_EN enables the reset_req_o pulse (otherwise tied 0).
module link_monitor #(
    parameter int GOOD_CYCLES    = 256,
    parameter int DROP_FILTER    = 4,
    parameter int REQ_CYCLES     = 16,
    parameter int HOLDOFF_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 mmcms_locked_i,
    input  logic                 gbt_rxready_i,
    input  logic                 gbt_rxvalid_i,
    input  logic                 gbt_txready_i,
    input  logic                 cnt_clear_i,
    output logic                 link_good_o,
    output logic                 reset_req_o,
    output logic [CNT_WIDTH-1:0] unlock_cnt_o,
    output logic [CNT_WIDTH-1:0] glitch_cnt_o,
    output logic [2:0]           state_o
);

    // state | meaning
    // IDLE  | waiting for first all-good cycle
    // QUAL  | counting consecutive all-good cycles
    // UP    | link qualified; filtering bad runs
    // REQ   | reset request pulse, fixed length
    // HOLD  | quiet holdoff before re-qualification
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_QUAL = 3'd1,
        ST_UP   = 3'd2,
        ST_REQ  = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    localparam int QW   = $clog2(GOOD_CYCLES + 1);
    localparam int BW   = $clog2(DROP_FILTER + 1);
    localparam int TMAX = (REQ_CYCLES > HOLDOFF_CYCLES) ? REQ_CYCLES : HOLDOFF_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [QW-1:0] QUAL_LAST = QW'(GOOD_CYCLES - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(DROP_FILTER - 1);
    localparam logic [TW-1:0] REQ_LOAD  = TW'(REQ_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLDOFF_CYCLES - 1);

    logic                 r_locked, r_rxready, r_rxvalid, r_txready;
    logic                 w_all_good;
    state_t               r_state, w_next_state;
    logic [QW-1:0]        r_qual_cnt, w_qual_cnt_nxt;
    logic [BW-1:0]        r_bad_cnt, w_bad_cnt_nxt;
    logic [TW-1:0]        r_timer, w_timer_nxt;
    logic                 w_unlock_inc, w_glitch_inc;
    logic [CNT_WIDTH-1:0] r_unlock_cnt, r_glitch_cnt;
    logic                 r_link_good, r_reset_req;

    assign w_all_good = r_locked & r_rxready & r_rxvalid & r_txready;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_locked   <= 1'b0;
            r_rxready  <= 1'b0;
            r_rxvalid  <= 1'b0;
            r_txready  <= 1'b0;
            r_state    <= ST_IDLE;
            r_qual_cnt <= '0;
            r_bad_cnt  <= '0;
            r_timer    <= '0;
        end else begin
            r_locked   <= mmcms_locked_i;
            r_rxready  <= gbt_rxready_i;
            r_rxvalid  <= gbt_rxvalid_i;
            r_txready  <= gbt_txready_i;
            r_state    <= w_next_state;
            r_qual_cnt <= w_qual_cnt_nxt;
            r_bad_cnt  <= w_bad_cnt_nxt;
            r_timer    <= w_timer_nxt;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_qual_cnt_nxt = r_qual_cnt;
        w_bad_cnt_nxt  = r_bad_cnt;
        w_timer_nxt    = r_timer;
        w_unlock_inc   = 1'b0;
        w_glitch_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_qual_cnt_nxt = '0;
                w_bad_cnt_nxt  = '0;
                if (w_all_good) begin
                    w_next_state   = ST_QUAL;
                    w_qual_cnt_nxt = QW'(1);
                end
            end
            ST_QUAL: begin
                if (!w_all_good) begin
                    w_next_state   = ST_IDLE;
                    w_qual_cnt_nxt = '0;
                end else if (r_qual_cnt >= QUAL_LAST) begin
                    w_next_state   = ST_UP;
                    w_qual_cnt_nxt = '0;
                    w_bad_cnt_nxt  = '0;
                end else begin
                    w_qual_cnt_nxt = r_qual_cnt + QW'(1);
                end
            end
            ST_UP: begin
                if (!w_all_good) begin
                    if (r_bad_cnt >= BAD_LAST) begin
                        w_next_state  = ST_REQ;
                        w_unlock_inc  = 1'b1;
                        w_bad_cnt_nxt = '0;
                        w_timer_nxt   = REQ_LOAD;
                    end else begin
                        w_bad_cnt_nxt = r_bad_cnt + BW'(1);
                    end
                end else begin
                    w_glitch_inc  = (r_bad_cnt != '0);
                    w_bad_cnt_nxt = '0;
                end
            end
            ST_REQ: begin
                if (r_timer == '0) begin
                    w_next_state = ST_HOLD;
                    w_timer_nxt  = HOLD_LOAD;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            ST_HOLD: begin
                if (r_timer == '0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: begin
                w_next_state   = ST_IDLE;
                w_qual_cnt_nxt = '0;
                w_bad_cnt_nxt  = '0;
                w_timer_nxt    = '0;
            end
        endcase
    end

    // Clear takes priority over a same-cycle increment; both counters saturate.
    always_ff @(posedge clock_i) begin
        if (reset_i || cnt_clear_i) begin
            r_unlock_cnt <= '0;
            r_glitch_cnt <= '0;
        end else begin
            if (w_unlock_inc && (r_unlock_cnt != '1)) r_unlock_cnt <= r_unlock_cnt + CNT_WIDTH'(1);
            if (w_glitch_inc && (r_glitch_cnt != '1)) r_glitch_cnt <= r_glitch_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_link_good <= 1'b0;
            r_reset_req <= 1'b0;
        end else begin
            r_link_good <= (r_state == ST_UP);
`ifdef LINK_MONITOR_AUTORESET_EN
            r_reset_req <= (r_state == ST_REQ);
`else
            r_reset_req <= 1'b0;
`endif
        end
    end

    assign link_good_o  = r_link_good;
    assign reset_req_o  = r_reset_req;
    assign unlock_cnt_o = r_unlock_cnt;
    assign glitch_cnt_o = r_glitch_cnt;
    assign state_o      = r_state;

endmodule

// File: tb/tb_link_monitor.sv
// Self-checking bench for link_monitor: directed scenarios plus random status bursts,
// all outputs compared every cycle against a time-based behavioural model.
module tb_link_monitor;
    localparam int G  = 8;
    localparam int D  = 4;
    localparam int R  = 4;
    localparam int H  = 16;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef LINK_MONITOR_AUTORESET_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic          clk;
    logic          reset_i, locked, rxready, rxvalid, txready, cnt_clear;
    logic          link_good_o, reset_req_o;
    logic [CW-1:0] unlock_cnt_o, glitch_cnt_o;
    logic [2:0]    state_o;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit cmp_en = 0;

    link_monitor #(.GOOD_CYCLES(G), .DROP_FILTER(D), .REQ_CYCLES(R),
                   .HOLDOFF_CYCLES(H), .CNT_WIDTH(CW)) dut (
        .clock_i(clk), .reset_i(reset_i), .mmcms_locked_i(locked),
        .gbt_rxready_i(rxready), .gbt_rxvalid_i(rxvalid), .gbt_txready_i(txready),
        .cnt_clear_i(cnt_clear), .link_good_o(link_good_o), .reset_req_o(reset_req_o),
        .unlock_cnt_o(unlock_cnt_o), .glitch_cnt_o(glitch_cnt_o), .state_o(state_o));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: phase numbers follow the published state encoding,
    // REQ/HOLD lengths are measured in absolute edge counts since phase entry.
    int m_phase = 0, m_goods = 0, m_bad = 0, m_tenter = 0;
    int m_unlock = 0, m_glitch = 0;
    bit m_link = 0, m_req = 0, m_agreg = 0;

    always @(posedge clk) begin
        bit ag, inc_u, inc_g;
        cyc = cyc + 1;
        if (reset_i) begin
            m_phase = 0; m_goods = 0; m_bad = 0; m_tenter = 0;
            m_unlock = 0; m_glitch = 0; m_link = 0; m_req = 0; m_agreg = 0;
        end else begin
            m_link = (m_phase == 2);
            m_req  = AUTO && (m_phase == 3);
            ag = m_agreg;
            inc_u = 0;
            inc_g = 0;
            case (m_phase)
                0: if (ag) begin m_phase = 1; m_goods = 1; end
                1: if (!ag) begin
                       m_phase = 0; m_goods = 0;
                   end else begin
                       m_goods++;
                       if (m_goods >= G) begin m_phase = 2; m_bad = 0; end
                   end
                2: if (!ag) begin
                       m_bad++;
                       if (m_bad >= D) begin m_phase = 3; m_tenter = cyc; inc_u = 1; m_bad = 0; end
                   end else begin
                       if (m_bad > 0) inc_g = 1;
                       m_bad = 0;
                   end
                3: if (cyc - m_tenter >= R) begin m_phase = 4; m_tenter = cyc; end
                default: if (cyc - m_tenter >= H) m_phase = 0;
            endcase
            if (cnt_clear) begin
                m_unlock = 0; m_glitch = 0;
            end else begin
                if (inc_u && m_unlock < CMAX) m_unlock++;
                if (inc_g && m_glitch < CMAX) m_glitch++;
            end
            m_agreg = locked & rxready & rxvalid & txready;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("link_good", int'(link_good_o), int'(m_link));
            chk("reset_req", int'(reset_req_o), int'(m_req));
            chk("unlock_cnt", int'(unlock_cnt_o), m_unlock);
            chk("glitch_cnt", int'(glitch_cnt_o), m_glitch);
            chk("state", int'(state_o), m_phase);
        end
    end

    task automatic set_all(input logic v);
        locked = v; rxready = v; rxvalid = v; txready = v;
    endtask

    task automatic wait_link(input logic val, input int lim, input string nm);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (link_good_o == val) return;
        end
        n_chk++;
        n_err++;
        $display("FAIL %s: timeout waiting link_good_o=%0d after %0d cycles", nm, val, lim);
    endtask

    task automatic drop_link(input int len);
        locked = 1'b0;
        repeat (len) @(negedge clk);
        locked = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1);
    end

    initial begin
        int c0, low_cnt, req_cnt, burst;
        bit found;
        reset_i = 1'b1; cnt_clear = 1'b0; set_all(1'b0);
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_link", int'(link_good_o), 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_unlock", int'(unlock_cnt_o), 0);

        // 1: qualification from reset release
        reset_i = 1'b0; set_all(1'b1); c0 = cyc;
        wait_link(1'b1, 40, "s1_wait");
        chk("s1_rise_latency", cyc - c0, 10);
        chk("s1_unlock", int'(unlock_cnt_o), 0);
        chk("s1_glitch", int'(glitch_cnt_o), 0);

        // 2: short glitch while up
        repeat (3) @(negedge clk);
        rxvalid = 1'b0;
        repeat (3) @(negedge clk);
        rxvalid = 1'b1;
        repeat (4) @(negedge clk);
        chk("s2_link", int'(link_good_o), 1);
        chk("s2_glitch", int'(glitch_cnt_o), 1);
        chk("s2_unlock", int'(unlock_cnt_o), 0);

        // 3: real drop, request pulse and recovery
        c0 = cyc; locked = 1'b0;
        wait_link(1'b0, 20, "s3_fall_wait");
        chk("s3_fall_latency", cyc - c0, D + 2);
        locked = 1'b1;
        low_cnt = 1; req_cnt = int'(reset_req_o);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (link_good_o) break;
            low_cnt++;
            req_cnt += int'(reset_req_o);
        end
        chk("s3_req_cycles", req_cnt, AUTO ? 4 : 0);
        chk("s3_low_cycles", low_cnt, 28);
        chk("s3_unlock", int'(unlock_cnt_o), 1);

        // 4: bad pulse during qualification restarts it
        reset_i = 1'b1; set_all(1'b0);
        @(negedge clk);
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
        set_all(1'b1);
        repeat (5) @(negedge clk);
        txready = 1'b0;
        @(negedge clk);
        txready = 1'b1; c0 = cyc;
        wait_link(1'b1, 40, "s4_wait");
        chk("s4_rise_latency", cyc - c0, 10);
        chk("s4_glitch", int'(glitch_cnt_o), 0);

        // 5: saturation, then clear colliding with an increment
        for (int k = 0; k < 17; k++) begin
            drop_link(5);
            wait_link(1'b1, 80, "s5_recover");
        end
        chk("s5_saturate", int'(unlock_cnt_o), 15);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        @(negedge clk);
        chk("s5_cleared", int'(unlock_cnt_o), 0);
        drop_link(5);
        wait_link(1'b1, 80, "s5_recover1");
        chk("s5_one", int'(unlock_cnt_o), 1);
        locked = 1'b0;
        repeat (4) @(negedge clk);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0; locked = 1'b1;
        @(negedge clk);
        chk("s5_clear_wins", int'(unlock_cnt_o), 0);
        wait_link(1'b1, 80, "s5_recover2");

        // 6: reset during REQ
        locked = 1'b0; found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state_o == 3'd3) begin found = 1; break; end
        end
        chk("s6_reached_req", int'(found), 1);
        reset_i = 1'b1; locked = 1'b1;
        @(negedge clk);
        chk("s6_link", int'(link_good_o), 0);
        chk("s6_req", int'(reset_req_o), 0);
        chk("s6_state", int'(state_o), 0);
        chk("s6_unlock", int'(unlock_cnt_o), 0);
        reset_i = 1'b0;

        // random status bursts
        burst = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            reset_i   = ($urandom_range(0, 599) == 0);
            cnt_clear = ($urandom_range(0, 99) == 0);
            if (burst > 0) begin
                burst--;
                if (burst == 0) set_all(1'b1);
            end else if ($urandom_range(0, 19) == 0) begin
                burst = $urandom_range(1, 7);
                case ($urandom_range(0, 3))
                    0: locked  = 1'b0;
                    1: rxready = 1'b0;
                    2: rxvalid = 1'b0;
                    default: txready = 1'b0;
                endcase
            end
        end
        reset_i = 1'b0; cnt_clear = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
